// File: rtl/snn_pkg.sv
// Shared types and default parameters for the leaky integrate-and-fire PE cluster.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } pe_state_e;

  typedef enum logic {
    CONV = 1'b0,
    POOL = 1'b1
  } pe_mode_e;

  localparam int DEF_WW       = 8;
  localparam int DEF_VW       = 12;
  localparam int DEF_NCH      = 4;
  localparam int DEF_LEAK_SH  = 3;
  localparam int DEF_HARD_RST = 0;

endpackage

// File: rtl/snn_sat_addsub.sv
// Signed add or subtract of two W-bit operands, clamped to the W-bit signed range.
module snn_sat_addsub #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);

  logic [W:0] w_ext;

  // One guard bit exposes overflow as a disagreement between the top two bits.
  always_comb begin
    w_ext = '0;
    if (i_sub) begin
      w_ext = {i_a[W-1], i_a} - {i_b[W-1], i_b};
    end else begin
      w_ext = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    end
    o_y = w_ext[W-1:0];
    if (w_ext[W] != w_ext[W-1]) begin
      o_y = w_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lif_pe_cluster.sv
// Cluster of NCH leaky integrate-and-fire neurons: a one-stage integrate pipeline
// feeding a flop membrane store, and a handshaked fire sweep at the end of each timestep.
module lif_pe_cluster
  import snn_pkg::*;
#(
  parameter int WW       = DEF_WW,
  parameter int VW       = DEF_VW,
  parameter int NCH      = DEF_NCH,
  parameter int LEAK_SH  = DEF_LEAK_SH,
  parameter int HARD_RST = DEF_HARD_RST,
  localparam int CW      = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic          in_spike,
  input  logic [WW-1:0] in_weight,
  input  logic          accum_src,
  input  logic [VW-1:0] vmem_in,
  input  logic [VW-1:0] vth,
  input  logic          step,
  output logic          step_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic          out_spike,
  output logic [VW-1:0] out_vmem,
  output logic          busy
);

  pe_state_e r_state;
  pe_state_e w_nextState;
  logic      r_stepHeld;
  logic      w_nextHeld;
  logic      r_stepErr;

  logic          r_pv;
  logic [CW-1:0] r_pch;
  pe_mode_e      r_pmode;
  logic          r_pspike;
  logic [WW-1:0] r_pweight;
  logic          r_psrc;
  logic [VW-1:0] r_pvin;

  logic [VW-1:0] r_vmem [NCH];
  logic [NCH-1:0] r_mode;

  logic [CW-1:0] r_fch;
  logic          r_fdone;
  logic          r_outValid;
  logic [CW-1:0] r_outCh;
  logic          r_outSpike;
  logic [VW-1:0] r_outVmem;

  logic          w_accept;
  logic          w_stepIn;
  logic          w_stepBad;
  logic          w_sweepEnd;
  logic          w_fload;
  logic [VW-1:0] w_pv;
  logic [VW-1:0] w_pweightExt;
  logic [VW-1:0] w_intSum;
  logic [VW-1:0] w_pnew;
  logic [VW-1:0] w_fv;
  logic [VW-1:0] w_fdiff;
  logic [VW-1:0] w_leakV;
  logic          w_fspike;
  logic [VW-1:0] w_fnew;

  // A held step blocks new beats so the pipeline can drain before the sweep.
  assign in_ready   = (r_state != FIRE) && !r_stepHeld;
  assign w_accept   = in_valid && in_ready;
  assign w_stepIn   = step && (r_state != FIRE) && !r_stepHeld;
  assign w_stepBad  = step && ((r_state == FIRE) || r_stepHeld);
  assign w_sweepEnd = r_outValid && out_ready && (r_outCh == CW'(NCH - 1));
  assign w_fload    = (r_state == FIRE) && !r_fdone && (!r_outValid || out_ready);

  assign busy      = (r_state == FIRE);
  assign step_err  = r_stepErr;
  assign out_valid = r_outValid;
  assign out_ch    = r_outCh;
  assign out_spike = r_outSpike;
  assign out_vmem  = r_outVmem;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_stepHeld <= 1'b0;
      r_stepErr  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_stepHeld <= w_nextHeld;
      r_stepErr  <= w_stepBad;
    end
  end

  // FIRE is entered only on a cycle with no accepted beat, so the stage drains on that same edge.
  always_comb begin
    w_nextState = r_state;
    w_nextHeld  = r_stepHeld;
    case (r_state)
      IDLE, ACCUM: begin
        if ((w_stepIn || r_stepHeld) && !w_accept) begin
          w_nextState = FIRE;
          w_nextHeld  = 1'b0;
        end else begin
          if (w_stepIn) begin
            w_nextHeld = 1'b1;
          end
          if ((r_state == IDLE) && w_accept) begin
            w_nextState = ACCUM;
          end
        end
      end
      FIRE: begin
        if (w_sweepEnd) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pv      <= 1'b0;
      r_pch     <= '0;
      r_pmode   <= CONV;
      r_pspike  <= 1'b0;
      r_pweight <= '0;
      r_psrc    <= 1'b0;
      r_pvin    <= '0;
    end else begin
      r_pv <= w_accept;
      if (w_accept) begin
        r_pch     <= in_ch;
        r_pmode   <= pe_mode_e'(mode);
        r_pspike  <= in_spike;
        r_pweight <= in_weight;
        r_psrc    <= accum_src;
        r_pvin    <= vmem_in;
      end
    end
  end

  assign w_pv         = r_vmem[r_pch];
  assign w_pweightExt = r_pspike ? {{(VW-WW){r_pweight[WW-1]}}, r_pweight} : '0;

  snn_sat_addsub #(.W(VW)) u_integrate (
    .i_a   (w_pv),
    .i_b   (w_pweightExt),
    .i_sub (1'b0),
    .o_y   (w_intSum)
  );

  always_comb begin
    w_pnew = w_intSum;
    if (r_psrc) begin
      w_pnew = r_pvin;
    end else if (r_pmode == POOL) begin
      w_pnew = {w_pv[VW-1:1], w_pv[0] | r_pspike};
    end
  end

  assign w_fv    = r_vmem[r_fch];
  assign w_leakV = (LEAK_SH == 0) ? w_fv : w_fv - VW'($signed(w_fv) >>> LEAK_SH);

  snn_sat_addsub #(.W(VW)) u_fire_sub (
    .i_a   (w_fv),
    .i_b   (vth),
    .i_sub (1'b1),
    .o_y   (w_fdiff)
  );

  always_comb begin
    w_fspike = 1'b0;
    w_fnew   = w_leakV;
    if (pe_mode_e'(r_mode[r_fch]) == POOL) begin
      w_fspike = w_fv[0];
      w_fnew   = '0;
    end else if ($signed(w_fv) > $signed(vth)) begin
      w_fspike = 1'b1;
      w_fnew   = (HARD_RST != 0) ? '0 : w_fdiff;
    end
  end

  // The integrate stage and the sweep never write in the same cycle: the stage is empty in FIRE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCH; i++) begin
        r_vmem[i] <= '0;
      end
      r_mode <= '0;
    end else if (r_pv) begin
      r_vmem[r_pch] <= w_pnew;
      r_mode[r_pch] <= r_pmode;
    end else if (w_fload) begin
      r_vmem[r_fch] <= w_fnew;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fch      <= '0;
      r_fdone    <= 1'b0;
      r_outValid <= 1'b0;
      r_outCh    <= '0;
      r_outSpike <= 1'b0;
      r_outVmem  <= '0;
    end else if (r_state != FIRE) begin
      r_fch   <= '0;
      r_fdone <= 1'b0;
    end else if (w_fload) begin
      r_outValid <= 1'b1;
      r_outCh    <= r_fch;
      r_outSpike <= w_fspike;
      r_outVmem  <= w_fnew;
      if (r_fch == CW'(NCH - 1)) begin
        r_fdone <= 1'b1;
      end else begin
        r_fch <= r_fch + CW'(1);
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: doc/lif_pe_cluster.md
LIF_PE_CLUSTER -- requirements
Module: lif_pe_cluster

Interface
REQ-001 SHALL take parameter WW, default 8: signed weight width in bits.
REQ-002 SHALL take parameter VW, default 12: signed membrane width in bits; VW >= WW+2.
REQ-003 SHALL take parameter NCH, default 4: neuron channels held in the cluster; power of 2; CW = $clog2(NCH).
REQ-004 SHALL take parameter LEAK_SH, default 3: leak shift per timestep; 0 disables leak.
REQ-005 SHALL take parameter HARD_RST, default 0: 1 means zero on fire; 0 means subtract vth on fire.
REQ-006 SHALL have these ports (clock and reset first):
  clk  in  1  clock
  nrst  in  1  asynchronous active-low reset
  mode  in  1  0 = conv (integrate), 1 = pool (spike-OR); sampled at each input beat
  in_valid  in  1  input beat valid
  in_ready  out  1  cluster accepts a beat this cycle
  in_ch  in  CW  target channel
  in_spike  in  1  presynaptic spike (index bit)
  in_weight  in  WW  signed synaptic weight
  accum_src  in  1  1 = load vmem_in into the channel instead of accumulating
  vmem_in  in  VW  external membrane value
  vth  in  VW  signed firing threshold, positive
  step  in  1  one-cycle pulse that ends the timestep and starts the fire sweep
  step_err  out  1  one-cycle pulse when step is ignored
  out_valid  out  1  fire-result beat valid
  out_ready  in  1  downstream accepts the beat
  out_ch  out  CW  channel of the result
  out_spike  out  1  fired flag
  out_vmem  out  VW  post-fire membrane value
  busy  out  1  high while in FIRE

Function
REQ-007 SHALL implement an FSM with states IDLE, ACCUM and FIRE.
- IDLE->ACCUM on the first accepted beat.
- IDLE/ACCUM->FIRE on step, once the pipeline is empty.
- FIRE->IDLE after the beat for channel NCH-1 is accepted.
REQ-008 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in FIRE.
REQ-009 SHALL update the channel of a beat accepted in cycle N at the clock edge ending cycle N+1 (one register stage).
REQ-010 SHALL forward the pending update, so back-to-back beats to the same channel accumulate correctly.
REQ-011 Conv update: v <= sat(v + (in_spike ? sign_ext(in_weight) : 0)), saturating to VW signed min/max.
REQ-012 Pool update: v <= v | in_spike (bit 0 only).
REQ-013 accum_src = 1 SHALL load vmem_in, overriding REQ-011/012 for that beat.
REQ-014 If step arrives while beats are in flight, the cluster SHALL deassert in_ready, let the pipeline drain, then enter FIRE; the step is held internally, not lost.
REQ-015 step in FIRE, or a second step while one is held, SHALL be ignored and SHALL pulse step_err for 1 cycle.
REQ-016 FIRE SHALL sweep channels 0..NCH-1 in order, one beat per channel, with handshake out_valid/out_ready.
- out_ch, out_spike and out_vmem SHALL hold stable while out_valid=1 and out_ready=0.
- Maximum throughput is 1 channel per cycle.
REQ-017 Conv fire rule: out_spike = (v > vth), signed compare.
- If spiked: v <= HARD_RST ? 0 : v - vth.
- If not spiked: v <= v - (v >>> LEAK_SH).
- The write-back value appears on out_vmem.
REQ-018 Pool fire rule: out_spike = v[0]; v <= 0.
REQ-019 The per-channel conv/pool interpretation SHALL follow the mode of the last beat written to that channel (one mode bit stored per channel).

Reset
REQ-020 Assertion of nrst at any time, including mid-FIRE or mid-stall, SHALL set all outputs and state as follows:
- FSM = IDLE; every channel v = 0 and stored mode = 0.
- Pipeline empty; held step cleared.
- out_valid = 0, out_ch = 0, out_spike = 0, out_vmem = 0, step_err = 0, busy = 0, in_ready = 1.
REQ-021 No state SHALL be retained across reset.

Structure
REQ-022 Package snn_pkg SHALL hold:
- state enum pe_state_e {IDLE, ACCUM, FIRE};
- mode enum pe_mode_e {CONV, POOL};
- the default parameter constants.
REQ-023 Saturating signed add/subtract SHALL live in sub-module snn_sat_addsub (parameter W), instantiated for integrate and for the fire subtract.
REQ-024 The membrane store SHALL be flops (NCH x VW), not a RAM macro.

Verification
REQ-025 Integrate: NCH=4, conv, ch1 beats with weights +5, +7, +9, spike=1, then a beat with weight +100, spike=0, then step with vth=20 -> ch1 out_spike=1, out_vmem=1 (soft reset); channels 0, 2, 3 give out_spike=0, out_vmem=0.
REQ-026 Saturation/leak: VW=12, load ch0 vmem_in=2040, add +127 -> v=2047; step with vth=2047 -> out_spike=0, out_vmem=2047-255=1792.
REQ-027 Backpressure: during FIRE hold out_ready=0 for 5 cycles at ch2 -> out_ch=2 and out_vmem stable, in_ready=0, busy=1; sweep completes after release.
REQ-028 Simultaneous events: step in the same cycle as an accepted beat to ch3 -> beat included in ch3 fire result; second step during FIRE -> step_err=1 for exactly 1 cycle, no extra sweep.
REQ-029 Pool and reset: pool beats to ch0 with spikes 0, 1, 0 -> out_spike=1, out_vmem=0; nrst asserted mid-sweep at ch1 -> all outputs at reset values next cycle, next step gives all spikes 0.
